// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial subtractor controller. A single 1-bit full-subtractor cell is
//   stepped across the operands LSB first. The borrow between bits is kept
//   in a flop. One operation takes WIDTH RUN cycles plus a one-cycle DONE.
//
//   Optional feature macro: SERIAL_SUB_OVERFLOW_EN
//     defined   -> out_overflow reports signed overflow of the subtraction
//     undefined -> out_overflow is tied low and no overflow logic exists
//
// Ports
//   in_clk        : clock, rising edge active
//   in_rst        : synchronous active-high reset
//   in_start      : start request, only looked at while out_ready is high
//   in_a, in_b    : minuend / subtrahend, captured on the accepting edge
//   in_borrow     : borrow into bit 0, captured on the accepting edge
//   out_ready     : high in IDLE
//   out_busy      : high in RUN
//   out_done      : one-cycle completion pulse
//   out_sub       : registered a - b - borrow_in (mod 2^WIDTH)
//   out_borrow    : registered borrow out of the MSB
//   out_overflow  : registered signed-overflow flag
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_ready,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_sub,
  output logic             out_borrow,
  output logic             out_overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bor_q, bor_d;
  logic [WIDTH-1:0]   sub_q, sub_d;
  logic               obor_q, obor_d;
  logic               done_q, done_d;

  logic               cell_a, cell_b, cell_diff, cell_bout;
  logic               last_bit;

  // Full-subtractor cell working on the current LSB of the shift registers.
  assign cell_a    = a_q[0];
  assign cell_b    = b_q[0];
  assign cell_diff = cell_a ^ cell_b ^ bor_q;
  assign cell_bout = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & bor_q);

  // The counter stops at WIDTH-1 instead of incrementing past it, so it
  // never wraps while RUN is active even when WIDTH is a power of two.
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bor_d   = bor_q;
    sub_d   = sub_q;
    obor_d  = obor_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          a_d     = in_a;
          b_d     = in_b;
          bor_d   = in_borrow;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bor_d  = cell_bout;
        // New difference bit enters at the MSB; after WIDTH shifts bit 0
        // of the result sits at diff[0].
        diff_d = (diff_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
        if (last_bit) begin
          sub_d   = diff_d;
          obor_d  = cell_bout;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      sub_q   <= '0;
      obor_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      sub_q   <= sub_d;
      obor_q  <= obor_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // On the last bit the cell sees the captured operand MSBs directly, and
  // cell_diff is the result MSB, so no extra copies of the operands are kept.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ST_RUN && last_bit) begin
      ovf_d = (cell_a != cell_b) && (cell_diff != cell_a);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_overflow = ovf_q;
`else
  assign out_overflow = 1'b0;
`endif

  assign out_ready  = (state_q == ST_IDLE);
  assign out_busy   = (state_q == ST_RUN);
  assign out_done   = done_q;
  assign out_sub    = sub_q;
  assign out_borrow = obor_q;

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand bit count (legal range 2..32).
REQ-002 The module SHALL have port in_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port in_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port in_start, input, 1 bit: request to begin a subtraction, sampled only while out_ready is high.
REQ-005 The module SHALL have ports in_a and in_b, input, WIDTH bits each: minuend and subtrahend, captured on the accepting edge.
REQ-006 The module SHALL have port in_borrow, input, 1 bit: initial borrow into bit 0, captured on the accepting edge.
REQ-007 The module SHALL have port out_ready, output, 1 bit: high only in IDLE.
REQ-008 The module SHALL have port out_busy, output, 1 bit: high only in RUN.
REQ-009 The module SHALL have port out_done, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have port out_sub, output, WIDTH bits: registered difference a - b - borrow_in (mod 2^WIDTH).
REQ-011 The module SHALL have port out_borrow, output, 1 bit: registered final borrow out of the MSB.
REQ-012 The module SHALL have port out_overflow, output, 1 bit: registered signed-overflow flag (see Configuration).

Function
REQ-013 The controller SHALL sequence one 1-bit full-subtractor cell (diff = a^b^bin; bout = ~a&b | ~(a^b)&bin) bit-serially, LSB first, with the borrow held in a flop between bits.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on in_start=1; RUN->DONE after bit WIDTH-1 is processed; DONE->IDLE unconditionally after one cycle.
REQ-015 On the accepting edge E0 it SHALL load in_a and in_b into shift registers, load in_borrow into the borrow flop, and clear the bit counter.
REQ-016 On each of edges E1..E_WIDTH it SHALL process exactly one bit, shift the partial-difference register and increment the counter.
REQ-017 out_done SHALL be high for exactly the one cycle following E_WIDTH, giving a latency of WIDTH+1 cycles from start-sample to done.
REQ-018 out_sub, out_borrow and out_overflow SHALL update only on edge E_WIDTH and SHALL hold their values until the next completion.
REQ-019 A start asserted while out_ready is low (RUN or DONE) SHALL be ignored and not queued.
REQ-020 Operand inputs SHALL be don't-care outside the accepting edge; changing them during RUN SHALL NOT affect the result.
REQ-021 The bit counter SHALL be sized ceil(log2(WIDTH)) bits and SHALL NOT wrap before RUN exits.
REQ-022 Back-to-back operation SHALL be supported: a start held high SHALL be accepted again in the IDLE cycle following DONE.

Reset
REQ-023 While in_rst=1 at a rising edge, the FSM SHALL go to IDLE, and counter, shift registers, borrow flop, out_sub, out_borrow, out_overflow and out_done SHALL all clear to 0.
REQ-024 Reset SHALL take priority over in_start and SHALL abort an operation in RUN or DONE with no done pulse issued.
REQ-025 In the first cycle after reset is released, out_ready SHALL be 1 and out_busy SHALL be 0.

Configuration
REQ-026 Macro SERIAL_SUB_OVERFLOW_EN defined: on E_WIDTH, out_overflow SHALL be set to (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands.
REQ-027 Macro SERIAL_SUB_OVERFLOW_EN undefined: out_overflow SHALL be tied to 0, the port SHALL remain present, and no overflow logic SHALL be synthesized.

Verification (WIDTH=8)
REQ-028 Start with a=0x05, b=0x03, bin=0 -> done 9 cycles after start-sample; out_sub=0x02, out_borrow=0, out_overflow=0.
REQ-029 Start with a=0x00, b=0x01, bin=0 -> out_sub=0xFF, out_borrow=1; start with a=0x10, b=0x0F, bin=1 -> out_sub=0x00, out_borrow=0.
REQ-030 Start with a=0x80, b=0x01, bin=0 -> out_sub=0x7F, out_borrow=0, out_overflow=1 with the macro defined and 0 without it.
REQ-031 Pulse start again and change in_a/in_b at cycles 3 and 5 of RUN -> both starts ignored; result reflects only the originally captured operands.
REQ-032 Assert in_rst at cycle 4 of RUN -> no done pulse; all outputs 0 and out_ready=1 on the cycle after release.
REQ-033 Hold start high continuously -> done pulses every WIDTH+2 cycles with correct results for each captured operand set.
